// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I main controller.
// State enum, opcodes, datapath select encodings, branch funct3 codes.
// ILLEGAL_TRAP_EN adds the terminal TRAP state.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_LUI      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11
`ifdef ILLEGAL_TRAP_EN
        ,
        S_TRAP     = 4'd12
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] ASA_PC    = 2'b00;
    localparam logic [1:0] ASA_OLDPC = 2'b01;
    localparam logic [1:0] ASA_RS1   = 2'b10;
    localparam logic [1:0] ASA_ZERO  = 2'b11;

    localparam logic [1:0] ASB_RS2   = 2'b00;
    localparam logic [1:0] ASB_IMM   = 2'b01;
    localparam logic [1:0] ASB_FOUR  = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/mc_control_fsm_branch.sv
// Branch condition evaluation: funct3 + ALU flags -> taken.
// Ports: i_funct3, i_zero, i_lt, i_ltu in; o_taken out.
module mc_branch_cond
    import mc_ctrl_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_zero,
    input  logic       i_lt,
    input  logic       i_ltu,
    output logic       o_taken
);

    always_comb begin
        o_taken = 1'b0;
        unique case (i_funct3)
            F3_BEQ:  o_taken = i_zero;
            F3_BNE:  o_taken = ~i_zero;
            F3_BLT:  o_taken = i_lt;
            F3_BGE:  o_taken = ~i_lt;
            F3_BLTU: o_taken = i_ltu;
            F3_BGEU: o_taken = ~i_ltu;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I main controller: FETCH/DECODE/EXECUTE/MEM/WB sequencing.
// In: clk, reset, opcode, funct3, zero, lt, ltu, mem_ready.
// Out: pc/ir/reg write enables, mem strobes, mux selects, illegal, state_o.
// ILLEGAL_TRAP_EN: illegal opcodes enter a terminal TRAP state.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int HANDSHAKE = 1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       illegal,
    output logic [3:0] state_o
);

    state_t r_state;
    state_t w_next;
    logic   w_rdy;
    logic   w_taken;
    logic   w_pc_write;
    logic   w_ir_write;
    logic   w_reg_write;
    logic   w_mem_req;
    logic   w_mem_write;

    assign w_rdy = (HANDSHAKE != 0) ? mem_ready : 1'b1;

    mc_branch_cond u_branch_cond (
        .i_funct3 (funct3),
        .i_zero   (zero),
        .i_lt     (lt),
        .i_ltu    (ltu),
        .o_taken  (w_taken)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_FETCH;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_write = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = ASA_PC;
        alu_src_b   = ASB_RS2;
        alu_op      = ALU_ADD;
        result_src  = RES_ALUOUT;
        unique case (r_state)
            S_FETCH: begin
                w_mem_req  = 1'b1;
                alu_src_b  = ASB_FOUR;
                result_src = RES_ALU;
                w_ir_write = w_rdy;
                w_pc_write = w_rdy;
                if (w_rdy)
                    w_next = S_DECODE;
            end
            S_DECODE: begin
                // Branch/jump target is formed here and held in ALUOut.
                alu_src_a = ASA_OLDPC;
                alu_src_b = ASB_IMM;
                case (opcode)
                    OP_LOAD,
                    OP_STORE:  w_next = S_MEMADR;
                    OP_RTYPE:  w_next = S_EXECR;
                    OP_ITYPE:  w_next = S_EXECI;
                    OP_BRANCH: w_next = S_BRANCH;
                    OP_JAL:    w_next = S_JAL;
                    OP_LUI:    w_next = S_LUI;
`ifdef ILLEGAL_TRAP_EN
                    default:   w_next = S_TRAP;
`else
                    // PC+4 already written in FETCH, so this is a NOP.
                    default:   w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a = ASA_RS1;
                alu_src_b = ASB_IMM;
                w_next    = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                adr_src   = 1'b1;
                if (w_rdy)
                    w_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = RES_MEM;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                adr_src     = 1'b1;
                if (w_rdy)
                    w_next = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = ASA_RS1;
                alu_op    = ALU_FUNCT;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = ASA_RS1;
                alu_src_b = ASB_IMM;
                alu_op    = ALU_FUNCT;
                w_next    = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = ASA_ZERO;
                alu_src_b = ASB_IMM;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = ASA_RS1;
                alu_op     = ALU_SUB;
                w_pc_write = w_taken;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = ASA_OLDPC;
                alu_src_b  = ASB_FOUR;
                w_pc_write = 1'b1;
                w_next     = S_ALUWB;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                w_next = S_TRAP;
            end
`endif
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Enables are killed while reset is high so no update leaks through.
    assign pc_write  = w_pc_write  & ~reset;
    assign ir_write  = w_ir_write  & ~reset;
    assign reg_write = w_reg_write & ~reset;
    assign mem_req   = w_mem_req   & ~reset;
    assign mem_write = w_mem_write & ~reset;
    assign state_o   = r_state;

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (r_state == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: vector table, directed
// multicycle sequences and randomized instruction stream vs reference.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       zero = 1'b0;
    logic       lt = 1'b0;
    logic       ltu = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, reg_write, mem_req, mem_write;
    logic       adr_src, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [3:0] state_o;

    mc_control_fsm #(.HANDSHAKE(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .lt         (lt),
        .ltu        (ltu),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    function automatic logic [4:0] enables();
        return {pc_write, ir_write, reg_write, mem_req, mem_write};
    endfunction

    // Branch rule written directly from the ISA meaning of funct3.
    function automatic bit ref_taken(input logic [2:0] f, input bit z,
                                     input bit l, input bit lu);
        bit cond;
        if (f[2:1] == 2'b01) return 1'b0;
        cond = (f[2] == 1'b0) ? z : (f[1] ? lu : l);
        return f[0] ? !cond : cond;
    endfunction

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       z, l, lu;
        logic [3:0] nst;
        logic       pcw;
        logic [1:0] a, b, aop;
    } vec_t;

    function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic z,
                                logic l, logic lu, logic [3:0] nst,
                                logic pcw, logic [1:0] a, logic [1:0] b,
                                logic [1:0] aop);
        vec_t v;
        v.op = op; v.f3 = f3; v.z = z; v.l = l; v.lu = lu;
        v.nst = nst; v.pcw = pcw; v.a = a; v.b = b; v.aop = aop;
        return v;
    endfunction

    localparam int NV = 14;
    vec_t vt[NV];

    logic [6:0] rops[8];
    logic [3:0] exp_st[11];
    logic       exp_bit[11];
    logic       rdy_pat[11];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ---------------- reset ----------------
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = OP_RTYPE;
        @(negedge clk);
        chk("rst_enables", 32'(enables()), 0);
        chk("rst_state", state_o, S_FETCH);
        chk("rst_illegal", illegal, 0);
        chk("rst_alu_src_b", alu_src_b, 2'b10);
        chk("rst_result_src", result_src, 2'b10);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_state", state_o, S_FETCH);
        chk("post_rst_ir_write", ir_write, 1);
        chk("post_rst_pc_write", pc_write, 1);
        tick();
        @(negedge clk);
        chk("post_rst_decode", state_o, S_DECODE);
        chk("post_rst_ir_pulse", ir_write, 0);

        // ---------------- vector table ----------------
        vt[0]  = mk(OP_RTYPE,  3'b000, 0, 0, 0, S_EXECR,  0, 2'b10, 2'b00, 2'b10);
        vt[1]  = mk(OP_ITYPE,  3'b000, 0, 0, 0, S_EXECI,  0, 2'b10, 2'b01, 2'b10);
        vt[2]  = mk(OP_LUI,    3'b000, 0, 0, 0, S_LUI,    0, 2'b11, 2'b01, 2'b00);
        vt[3]  = mk(OP_LOAD,   3'b010, 0, 0, 0, S_MEMADR, 0, 2'b10, 2'b01, 2'b00);
        vt[4]  = mk(OP_STORE,  3'b010, 0, 0, 0, S_MEMADR, 0, 2'b10, 2'b01, 2'b00);
        vt[5]  = mk(OP_JAL,    3'b000, 0, 0, 0, S_JAL,    1, 2'b01, 2'b10, 2'b00);
        vt[6]  = mk(OP_BRANCH, 3'b000, 1, 0, 0, S_BRANCH, 1, 2'b10, 2'b00, 2'b01);
        vt[7]  = mk(OP_BRANCH, 3'b001, 1, 0, 0, S_BRANCH, 0, 2'b10, 2'b00, 2'b01);
        vt[8]  = mk(OP_BRANCH, 3'b110, 0, 0, 1, S_BRANCH, 1, 2'b10, 2'b00, 2'b01);
        vt[9]  = mk(OP_BRANCH, 3'b010, 1, 1, 1, S_BRANCH, 0, 2'b10, 2'b00, 2'b01);
        vt[10] = mk(OP_BRANCH, 3'b100, 0, 1, 0, S_BRANCH, 1, 2'b10, 2'b00, 2'b01);
        vt[11] = mk(OP_BRANCH, 3'b101, 0, 1, 0, S_BRANCH, 0, 2'b10, 2'b00, 2'b01);
        vt[12] = mk(OP_BRANCH, 3'b111, 0, 0, 0, S_BRANCH, 1, 2'b10, 2'b00, 2'b01);
        vt[13] = mk(OP_BRANCH, 3'b001, 0, 0, 0, S_BRANCH, 1, 2'b10, 2'b00, 2'b01);
        for (int i = 0; i < NV; i++) begin
            do_reset();
            opcode = vt[i].op; funct3 = vt[i].f3;
            zero = vt[i].z; lt = vt[i].l; ltu = vt[i].lu;
            mem_ready = 1'b1;
            tick();
            tick();
            @(negedge clk);
            chk($sformatf("vec%0d_state", i), state_o, vt[i].nst);
            chk($sformatf("vec%0d_pc_write", i), pc_write, vt[i].pcw);
            chk($sformatf("vec%0d_alu_src_a", i), alu_src_a, vt[i].a);
            chk($sformatf("vec%0d_alu_src_b", i), alu_src_b, vt[i].b);
            chk($sformatf("vec%0d_alu_op", i), alu_op, vt[i].aop);
        end

        // ---------------- R-type, 4 cycles ----------------
        do_reset();
        opcode = OP_RTYPE;
        mem_ready = 1'b1;
        exp_st[0] = S_FETCH; exp_st[1] = S_DECODE; exp_st[2] = S_EXECR;
        exp_st[3] = S_ALUWB; exp_st[4] = S_FETCH;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rtype_c%0d_state", i), state_o, exp_st[i]);
            chk($sformatf("rtype_c%0d_reg_write", i), reg_write, (i == 3));
            tick();
        end

        // ---------------- load with stalls, 10 cycles ----------------
        do_reset();
        opcode = OP_LOAD;
        for (int i = 0; i < 11; i++) rdy_pat[i] = 1'b0;
        rdy_pat[2] = 1'b1; rdy_pat[8] = 1'b1; rdy_pat[10] = 1'b0;
        exp_st[0] = S_FETCH;   exp_st[1] = S_FETCH;   exp_st[2] = S_FETCH;
        exp_st[3] = S_DECODE;  exp_st[4] = S_MEMADR;  exp_st[5] = S_MEMREAD;
        exp_st[6] = S_MEMREAD; exp_st[7] = S_MEMREAD; exp_st[8] = S_MEMREAD;
        exp_st[9] = S_MEMWB;   exp_st[10] = S_FETCH;
        for (int i = 0; i < 11; i++) begin
            mem_ready = rdy_pat[i];
            @(negedge clk);
            chk($sformatf("load_c%0d_state", i), state_o, exp_st[i]);
            chk($sformatf("load_c%0d_ir_write", i), ir_write, (i == 2));
            chk($sformatf("load_c%0d_reg_write", i), reg_write, (i == 9));
            if (i == 9)
                chk("load_memwb_result_src", result_src, 2'b01);
            tick();
        end

        // ---------------- store, reset during stall ----------------
        do_reset();
        opcode = OP_STORE;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("store_stall1_state", state_o, S_MEMWRITE);
        chk("store_stall1_mem_write", mem_write, 1);
        tick();
        #2;
        chk("store_stall2_mem_write", mem_write, 1);
        chk("store_stall2_mem_req", mem_req, 1);
        reset = 1'b1;
        #1;
        chk("store_rst_mem_write", mem_write, 0);
        chk("store_rst_mem_req", mem_req, 0);
        chk("store_rst_state", state_o, S_FETCH);
        chk("store_rst_pc_reg", {pc_write, reg_write}, 0);
        mem_ready = 1'b1;
        @(negedge clk);
        chk("store_rst_hold_enables", 32'(enables()), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("store_after_state", state_o, S_FETCH);
        chk("store_after_pc_reg", {pc_write, reg_write, ir_write}, 0);

        // ---------------- illegal opcode ----------------
        do_reset();
        opcode = 7'b0001111;
        mem_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("ill_decode_state", state_o, S_DECODE);
        chk("ill_decode_illegal", illegal, 0);
        tick();
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk($sformatf("trap_c%0d_state", i), state_o, S_TRAP);
            chk($sformatf("trap_c%0d_illegal", i), illegal, 1);
            chk($sformatf("trap_c%0d_enables", i), 32'(enables()), 0);
            tick();
        end
`else
        @(negedge clk);
        chk("ill_back_to_fetch", state_o, S_FETCH);
        chk("ill_illegal_low", illegal, 0);
        chk("ill_next_ir_write", ir_write, 1);
        tick();
        @(negedge clk);
        chk("ill_next_decode", state_o, S_DECODE);
`endif

        // ---------------- randomized stream vs reference ----------------
        begin
            int ndone, cyc, stalls, npcw, nirw, nrw, nreq, nmw, kind;
            int base, exp_pcw, exp_rw, exp_mem;
            bit left, tk;
            rops[0] = OP_RTYPE;  rops[1] = OP_ITYPE; rops[2] = OP_LUI;
            rops[3] = OP_LOAD;   rops[4] = OP_STORE; rops[5] = OP_BRANCH;
            rops[6] = OP_JAL;    rops[7] = 7'b0001111;
            do_reset();
            ndone = 0;
`ifdef ILLEGAL_TRAP_EN
            kind = $urandom_range(0, 6);
`else
            kind = $urandom_range(0, 7);
`endif
            opcode = rops[kind];
            funct3 = 3'($urandom_range(0, 7));
            zero = 1'($urandom_range(0, 1));
            lt = 1'($urandom_range(0, 1));
            ltu = 1'($urandom_range(0, 1));
            cyc = 0; stalls = 0; npcw = 0; nirw = 0; nrw = 0;
            nreq = 0; nmw = 0; left = 0;
            for (int c = 0; c < 3000 && ndone < 40; c++) begin
                mem_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (state_o == S_FETCH && left) begin
                    tk = ref_taken(funct3, zero, lt, ltu);
                    case (kind)
                        3: base = 5;
                        5: base = 3;
                        7: base = 2;
                        default: base = 4;
                    endcase
                    exp_pcw = 1 + ((kind == 6) ? 1 : 0) +
                              ((kind == 5 && tk) ? 1 : 0);
                    exp_rw = (kind <= 3 || kind == 6) ? 1 : 0;
                    exp_mem = (kind == 3 || kind == 4) ? 2 : 1;
                    chk($sformatf("rnd%0d_k%0d_cycles", ndone, kind), cyc, base + stalls);
                    chk($sformatf("rnd%0d_k%0d_pc_write", ndone, kind), npcw, exp_pcw);
                    chk($sformatf("rnd%0d_k%0d_ir_write", ndone, kind), nirw, 1);
                    chk($sformatf("rnd%0d_k%0d_reg_write", ndone, kind), nrw, exp_rw);
                    chk($sformatf("rnd%0d_k%0d_mem_req", ndone, kind), nreq, exp_mem + stalls);
                    chk($sformatf("rnd%0d_k%0d_mem_write", ndone, kind), (nmw > 0), (kind == 4));
                    ndone++;
`ifdef ILLEGAL_TRAP_EN
                    kind = $urandom_range(0, 6);
`else
                    kind = $urandom_range(0, 7);
`endif
                    opcode = rops[kind];
                    funct3 = 3'($urandom_range(0, 7));
                    zero = 1'($urandom_range(0, 1));
                    lt = 1'($urandom_range(0, 1));
                    ltu = 1'($urandom_range(0, 1));
                    cyc = 0; stalls = 0; npcw = 0; nirw = 0; nrw = 0;
                    nreq = 0; nmw = 0; left = 0;
                end
                if (state_o != S_FETCH) left = 1;
                cyc++;
                npcw += int'(pc_write);
                nirw += int'(ir_write);
                nrw += int'(reg_write);
                nreq += int'(mem_req);
                nmw += int'(mem_write);
                if (mem_req && !mem_ready) stalls++;
                tick();
            end
            if (ndone < 40)
                chk("rnd_instr_completed", ndone, 40);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
